// File: rtl/snake_pkg.sv
// snake_pkg: shared constants for the snake keyboard controller.
// Heading encoding, scan-code-set-2 codes and the key-capture FSM state type.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_R     = 8'h2D;

  // Arrow-key final bytes; the E0 prefix is stripped upstream, so the
  // keypad 8/6/2/4 keys alias onto these.
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } key_state_t;

endpackage

// File: rtl/snake_dir_fifo.sv
// snake_dir_fifo: DEPTH x 2-bit direction queue with head and tail peek.
// A push while full is only taken when a pop happens in the same cycle.
module snake_dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [1:0]               din,
  input  logic                     pop,
  output logic [1:0]               head,
  output logic [1:0]               tail,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - PTR_ONE];

  // Pointers and occupancy; flush discards every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/snake_key_ctrl.sv
// snake_key_ctrl: brings PS/2 release events into the clk domain, decodes
// them into snake commands and queues heading changes between game ticks.
// Optional build macro SNAKE_ARROW_KEYS_EN also decodes the arrow keys.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a falling edge of the synchronised release flag
//   ST_SETTLE | counting down so the synchronised key_code is stable
//   ST_SAMPLE | code captured; pulse key_event and act on the decode
module snake_key_ctrl
  import snake_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int QDEPTH        = 4,
  parameter int INIT_DIR      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               key_code,
  input  logic                     key_release,
  input  logic                     game_tick,
  output logic [1:0]               dir,
  output logic                     paused,
  output logic                     restart,
  output logic                     key_event,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0]    INIT_D   = 2'(INIT_DIR);

  logic       rel_s1, rel_s2, rel_s2_d;
  logic [7:0] code_s1, code_s2, code_q;
  logic       rel_fall;
  key_state_t state, state_nxt;
  logic [CW-1:0] cnt;

  logic       dir_req_vld;
  logic [1:0] dir_req;
  logic       pause_tgl;

  logic [1:0] q_head, q_tail, q_ref;
  logic       q_full, q_empty;
  logic       do_push, do_pop;

  // Two-flop synchronisers; one extra flop on the flag for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_s1   <= 1'b0;
      rel_s2   <= 1'b0;
      rel_s2_d <= 1'b0;
      code_s1  <= '0;
      code_s2  <= '0;
    end else begin
      rel_s1   <= key_release;
      rel_s2   <= rel_s1;
      rel_s2_d <= rel_s2;
      code_s1  <= key_code;
      code_s2  <= code_s1;
    end
  end

  // The decoder changes key_code as the flag drops, so the falling edge is the event.
  assign rel_fall = rel_s2_d & ~rel_s2;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; edges arriving outside IDLE are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rel_fall) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Settle down-counter and code capture at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      code_q <= '0;
    end else begin
      if (state == ST_IDLE && rel_fall) cnt <= CNT_LOAD;
      else if (state == ST_SETTLE && cnt != '0) cnt <= cnt - CNT_ONE;
      if (state == ST_SETTLE && cnt == '0) code_q <= code_s2;
    end
  end

  // FSM outputs: key_event plus the command decode of the captured code.
  always_comb begin
    key_event   = 1'b0;
    restart     = 1'b0;
    pause_tgl   = 1'b0;
    dir_req_vld = 1'b0;
    dir_req     = DIR_UP;
    if (state == ST_SAMPLE) begin
      key_event = 1'b1;
      case (code_q)
        KEY_W:     begin dir_req_vld = 1'b1; dir_req = DIR_UP;    end
        KEY_D:     begin dir_req_vld = 1'b1; dir_req = DIR_RIGHT; end
        KEY_S:     begin dir_req_vld = 1'b1; dir_req = DIR_DOWN;  end
        KEY_A:     begin dir_req_vld = 1'b1; dir_req = DIR_LEFT;  end
`ifdef SNAKE_ARROW_KEYS_EN
        KEY_UP:    begin dir_req_vld = 1'b1; dir_req = DIR_UP;    end
        KEY_RIGHT: begin dir_req_vld = 1'b1; dir_req = DIR_RIGHT; end
        KEY_DOWN:  begin dir_req_vld = 1'b1; dir_req = DIR_DOWN;  end
        KEY_LEFT:  begin dir_req_vld = 1'b1; dir_req = DIR_LEFT;  end
`endif
        KEY_SPACE: pause_tgl = 1'b1;
        KEY_R:     restart   = 1'b1;
        default:   ;
      endcase
    end
  end

  // New requests are judged against the last heading the snake will have taken.
  assign q_ref   = q_empty ? dir : q_tail;
  assign do_pop  = game_tick & ~paused & ~q_empty & ~restart;
  assign do_push = dir_req_vld
                 & (dir_req != q_ref)
                 & (dir_req != (q_ref ^ 2'b10))
                 & (~q_full | do_pop);

  snake_dir_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (restart),
    .push  (do_push),
    .din   (dir_req),
    .pop   (do_pop),
    .head  (q_head),
    .tail  (q_tail),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Heading and pause state; restart overrides a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir    <= INIT_D;
      paused <= 1'b0;
    end else if (restart) begin
      dir    <= INIT_D;
      paused <= 1'b0;
    end else begin
      if (do_pop)    dir    <= q_head;
      if (pause_tgl) paused <= ~paused;
    end
  end

endmodule

// File: tb/tb_snake_key_ctrl.sv
// tb_snake_key_ctrl: scoreboard bench for snake_key_ctrl against a queue-based
// model of the command rules.
module tb_snake_key_ctrl;

  localparam int SETTLE = 16;
  localparam int QD     = 4;
  localparam int INIT   = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           key_code;
  logic                 key_release;
  logic                 game_tick;
  logic [1:0]           dir;
  logic                 paused;
  logic                 restart;
  logic                 key_event;
  logic [$clog2(QD):0]  q_count;

  always #5 clk = ~clk;

  snake_key_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .QDEPTH        (QD),
    .INIT_DIR      (INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_release (key_release),
    .game_tick   (game_tick),
    .dir         (dir),
    .paused      (paused),
    .restart     (restart),
    .key_event   (key_event),
    .q_count     (q_count)
  );

  typedef struct {
    bit kev;
    bit rs;
    int dir;
    int qc;
    bit paused;
  } exp_t;

  exp_t sb[$];
  int   mq[$];
  int   mdir;
  bit   mpaused;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic int code_dir(input logic [7:0] c);
    case (c)
      8'h1D: return 0;
      8'h23: return 1;
      8'h1B: return 2;
      8'h1C: return 3;
`ifdef SNAKE_ARROW_KEYS_EN
      8'h75: return 0;
      8'h74: return 1;
      8'h72: return 2;
      8'h6B: return 3;
`endif
      default: return -1;
    endcase
  endfunction

  // Reference model: one DUT action (key decode and/or tick) -> expected outcome.
  task automatic model_step(input bit has_key, input logic [7:0] code, input bit tick);
    exp_t e;
    int   d, ref_d;
    bit   rs, pop, acc;
    rs  = has_key && (code == 8'h2D);
    pop = tick && !mpaused && (mq.size() > 0) && !rs;
    d   = has_key ? code_dir(code) : -1;
    if (rs) begin
      mq.delete();
      mdir    = INIT;
      mpaused = 1'b0;
    end else begin
      ref_d = (mq.size() > 0) ? mq[mq.size()-1] : mdir;
      acc   = (d >= 0) && (d != ref_d) && (d != (ref_d ^ 2)) && ((mq.size() < QD) || pop);
      if (pop) mdir = mq.pop_front();
      if (acc) mq.push_back(d);
      if (has_key && code == 8'h29) mpaused = !mpaused;
    end
    e.kev = has_key; e.rs = rs; e.dir = mdir; e.qc = mq.size(); e.paused = mpaused;
    sb.push_back(e);
  endtask

  // Release pulse; key_code changes exactly as the flag falls (on a negedge).
  task automatic key_fall(input logic [7:0] code);
    key_release = 1'b1;
    key_code    = 8'($urandom);
    repeat (3) @(negedge clk);
    key_code    = code;
    key_release = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] code, output int lat);
    model_step(1'b1, code, 1'b0);
    key_fall(code);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk); #1;
      if (key_event) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      $display("FAIL key_timeout: no key_event for code %h, want one within 60 cycles", code);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick();
    model_step(1'b0, 8'h00, 1'b1);
    @(negedge clk); game_tick = 1'b1;
    @(negedge clk); game_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic key_with_tick(input logic [7:0] code);
    model_step(1'b1, code, 1'b1);
    key_fall(code);
    repeat (SETTLE + 3) @(negedge clk);
    game_tick = 1'b1;
    @(negedge clk); game_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pop an expectation whenever the DUT acts, compare the pulses now
  // and the registered results one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && (key_event || game_tick)) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: key_event=%0d game_tick=%0d, want no pending action",
                   key_event, game_tick);
        end else begin
          e = sb.pop_front();
          chk("key_event", key_event, e.kev);
          chk("restart", restart, e.rs);
          @(negedge clk); #1;
          chk("dir", dir, e.dir);
          chk("q_count", q_count, e.qc);
          chk("paused", paused, e.paused);
          chk("restart_width", restart, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int lat, seen, r, k;
    logic [7:0] code;
    logic [7:0] codes [14];
    codes = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h23, 8'h1B, 8'h1C,
              8'h29, 8'h2D, 8'h75, 8'h74, 8'h72, 8'h6B};

    rst = 1'b1; key_code = '0; key_release = 1'b0; game_tick = 1'b0;
    mdir = INIT; mpaused = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("reset_dir", dir, INIT);
    chk("reset_paused", paused, 0);
    chk("reset_restart", restart, 0);
    chk("reset_key_event", key_event, 0);
    chk("reset_q_count", q_count, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Duplicate D from reset, with latency
    send_key(8'h23, lat);
    chk("latency", lat, SETTLE + 3);

    // W, A then two ticks
    send_key(8'h1D, lat);
    send_key(8'h1C, lat);
    do_tick();
    do_tick();

    // Reversal against dir=3, restart, reversal against dir=1, fill, overflow
    send_key(8'h23, lat);
    send_key(8'h2D, lat);
    send_key(8'h1C, lat);
    send_key(8'h1D, lat);
    send_key(8'h1C, lat);
    send_key(8'h1B, lat);
    send_key(8'h23, lat);
    send_key(8'h1D, lat);

    // Full queue, push coincident with pop
    key_with_tick(8'h1D);

    // Pause blocks pop, unpause resumes
    send_key(8'h29, lat);
    do_tick();
    send_key(8'h29, lat);
    do_tick();

    // Restart with three pending entries
    send_key(8'h2D, lat);

    // Reset mid-SETTLE with state away from reset values
    send_key(8'h1B, lat);
    send_key(8'h1C, lat);
    send_key(8'h29, lat);
    key_fall(8'h23);
    repeat (8) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_dir", dir, INIT);
    chk("midrst_paused", paused, 0);
    chk("midrst_q_count", q_count, 0);
    chk("midrst_key_event", key_event, 0);
    chk("midrst_restart", restart, 0);
    mq.delete(); mdir = INIT; mpaused = 1'b0;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < SETTLE + 20; i++) begin
      @(negedge clk); #1;
      if (key_event) seen++;
    end
    chk("lost_event", seen, 0);
    send_key(8'h1B, lat);

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 15);
      if (k < 14) code = codes[k];
      else        code = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5)      send_key(code, lat);
      else if (r <= 8) do_tick();
      else             key_with_tick(code);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
